change_dispenser: RTL and testbench

Downstream of the vending controller. Takes the change amount the controller computes on each transaction and pays it out as a sequence of individual coin-eject requests to the coin hopper, largest coin first. Tracks per-coin hopper stock, falls back to smaller coins when a tube is empty, and flags any amount it cannot pay. Runs in the controller's clock domain.

---
 rtl/change_dispenser.sv | 194 +++++++++++++++++++
 tb/tb_change_dispenser.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser
//
// Pays out a change amount as a series of single coin-eject requests to the
// coin hopper, largest coin first. Keeps a 4-bit stock count per coin tube,
// falls back to smaller coins when a tube is empty, and reports any amount
// that cannot be paid.
//
// Optional feature macro: CHANGE_PENNY_EN
//    defined   -> a penny tube exists (code 4, stocked from STOCK_P)
//    undefined -> quarters, dimes and nickels only; code 4 is never issued
//
// Parameters:
//    STOCK_Q/D/N/P  coins loaded into each tube at reset and on refill (0-15)
//
// Ports:
//    clk          system clock, rising edge
//    reset        synchronous, active-high
//    load         start a payout (accepted only in IDLE)
//    change_in    amount to pay, cents 0-63
//    refill       reload every tube from the parameters (IDLE only, load wins)
//    eject_ack    hopper accepted the coin currently requested
//    eject_valid  a coin request is pending
//    eject_coin   1=nickel 2=dime 3=quarter 4=penny, 0 when no request
//    busy         high in every state except IDLE
//    done         one-cycle pulse at the end of a payout
//    short        payout ended with an unpaid remainder; held until next load
//    remaining    cents still owed
module change_dispenser #(
   parameter int unsigned STOCK_Q = 8,
   parameter int unsigned STOCK_D = 8,
   parameter int unsigned STOCK_N = 8,
   parameter int unsigned STOCK_P = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [5:0] change_in,
   input  logic       refill,
   input  logic       eject_ack,
   output logic       eject_valid,
   output logic [2:0] eject_coin,
   output logic       busy,
   output logic       done,
   output logic       short,
   output logic [5:0] remaining
);

`ifdef CHANGE_PENNY_EN
   localparam int NUM_COINS = 4;
`else
   localparam int NUM_COINS = 3;
`endif

   // Tube index order is also the selection priority: quarter, dime,
   // nickel, penny. The penny entry is simply never reached when the
   // penny tube is not built.
   localparam logic [5:0] COIN_VALUE [4] = '{6'd25, 6'd10, 6'd5, 6'd1};
   localparam logic [2:0] COIN_CODE  [4] = '{3'd3, 3'd2, 3'd1, 3'd4};
   localparam logic [3:0] STOCK_INIT [4] = '{4'(STOCK_Q), 4'(STOCK_D),
                                             4'(STOCK_N), 4'(STOCK_P)};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SELECT = 2'd1,
      EJECT  = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t      state_reg;
   logic [5:0]  remaining_reg;
   logic [1:0]  coin_idx_reg;
   logic        eject_valid_reg;
   logic [2:0]  eject_coin_reg;
   logic        busy_reg;
   logic        done_reg;
   logic        short_reg;

   // All tube counters packed side by side, 4 bits per tube.
   logic [4*NUM_COINS-1:0] stock_flat;

   logic        pick_found;
   logic [1:0]  pick_idx;

   // Refill is only honoured while idle, and a simultaneous load takes
   // precedence.
   logic        refill_take;
   // Counts the coin the hopper just accepted.
   logic        coin_taken;

   assign refill_take = (state_reg == IDLE) && refill && !load;
   assign coin_taken  = (state_reg == EJECT) && eject_ack;

   // One counter per tube. Reset and refill both restore the parameter
   // value; an accepted coin decrements only its own tube, saturating at 0.
   generate
      for (genvar gi = 0; gi < NUM_COINS; gi++) begin : g_tube
         logic [3:0] stock_reg;

         always_ff @(posedge clk) begin
            if (reset || refill_take) begin
               stock_reg <= STOCK_INIT[gi];
            end else if (coin_taken && (coin_idx_reg == 2'(gi)) &&
                         (stock_reg != 4'd0)) begin
               stock_reg <= stock_reg - 4'd1;
            end
         end

         assign stock_flat[gi*4 +: 4] = stock_reg;
      end
   endgenerate

   // Largest coin that still fits the remainder and has stock left.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = 2'd0;
      for (int i = 0; i < NUM_COINS; i++) begin
         if (!pick_found && (stock_flat[i*4 +: 4] != 4'd0) &&
             (COIN_VALUE[i] <= remaining_reg)) begin
            pick_found = 1'b1;
            pick_idx   = 2'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= IDLE;
         remaining_reg   <= 6'd0;
         coin_idx_reg    <= 2'd0;
         eject_valid_reg <= 1'b0;
         eject_coin_reg  <= 3'd0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
         short_reg       <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (load) begin
                  remaining_reg <= change_in;
                  short_reg     <= 1'b0;
                  busy_reg      <= 1'b1;
                  state_reg     <= SELECT;
               end
            end

            SELECT: begin
               if (remaining_reg == 6'd0) begin
                  short_reg <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end else if (!pick_found) begin
                  short_reg <= 1'b1;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end else begin
                  coin_idx_reg    <= pick_idx;
                  eject_valid_reg <= 1'b1;
                  eject_coin_reg  <= COIN_CODE[pick_idx];
                  state_reg       <= EJECT;
               end
            end

            EJECT: begin
               // Request stays stable until the hopper takes the coin.
               // The coin was chosen with value <= remainder, so no underflow.
               if (eject_ack) begin
                  remaining_reg   <= remaining_reg - COIN_VALUE[coin_idx_reg];
                  eject_valid_reg <= 1'b0;
                  eject_coin_reg  <= 3'd0;
                  state_reg       <= SELECT;
               end
            end

            DONE: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign eject_valid = eject_valid_reg;
   assign eject_coin  = eject_coin_reg;
   assign busy        = busy_reg;
   assign done        = done_reg;
   assign short       = short_reg;
   assign remaining   = remaining_reg;

endmodule

// File: tb/tb_change_dispenser.sv
// Testbench for change_dispenser (default tube stocks of 8).
// Expected payouts come from a greedy cash-drawer model kept here, which
// tracks tube contents as plain integers. Build with or without
// CHANGE_PENNY_EN; the model follows the same macro.
module tb_change_dispenser;

   logic       clk = 1'b0;
   logic       reset;
   logic       load;
   logic [5:0] change_in;
   logic       refill;
   logic       eject_ack;
   logic       eject_valid;
   logic [2:0] eject_coin;
   logic       busy;
   logic       done;
   logic       short;
   logic [5:0] remaining;

   always #5 clk = ~clk;

   change_dispenser dut (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .change_in   (change_in),
      .refill      (refill),
      .eject_ack   (eject_ack),
      .eject_valid (eject_valid),
      .eject_coin  (eject_coin),
      .busy        (busy),
      .done        (done),
      .short       (short),
      .remaining   (remaining)
   );

`ifdef CHANGE_PENNY_EN
   localparam int NC = 4;
`else
   localparam int NC = 3;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Cash-drawer model: coin values, hopper codes, coins in each tube.
   int m_value [4] = '{25, 10, 5, 1};
   int m_code  [4] = '{3, 2, 1, 4};
   int m_stock [4];
   int exp_q[$];
   int obs_q[$];
   bit exp_short;
   int exp_rem;

   task automatic model_refill();
      for (int i = 0; i < 4; i++) m_stock[i] = 8;
   endtask

   // Pay greedily: biggest coin that fits and is in stock, until paid
   // or nothing fits.
   task automatic model_pay(input int amt);
      int  rem;
      int  pick;
      exp_q.delete();
      rem = amt;
      exp_short = 1'b0;
      forever begin
         if (rem == 0) break;
         pick = -1;
         for (int i = NC - 1; i >= 0; i--)
            if (m_stock[i] > 0 && m_value[i] <= rem) pick = i;
         if (pick < 0) begin
            exp_short = 1'b1;
            break;
         end
         exp_q.push_back(m_code[pick]);
         rem -= m_value[pick];
         m_stock[pick]--;
      end
      exp_rem = rem;
   endtask

   task automatic do_refill();
      @(negedge clk);
      refill = 1'b1;
      @(negedge clk);
      refill = 1'b0;
      model_refill();
   endtask

   // One payout. fixed_delay >= 0 holds every ack off that many cycles;
   // otherwise delays are random in 0..max_delay. noise toggles load,
   // change_in, refill and stray acks while busy (all must be ignored).
   task automatic run_txn(input string name, input int amt, input int fixed_delay,
                          input int max_delay, input bit noise, input bit refill_too);
      int cycles, exp_lat, valid_cycles, exp_valid, cnt, d, cur;
      bit in_coin, got_done, seq_bad;
      model_pay(amt);
      obs_q.delete();
      @(negedge clk);
      load = 1'b1;
      change_in = 6'(amt);
      refill = refill_too;
      eject_ack = 1'b0;
      @(negedge clk);
      load = 1'b0;
      refill = 1'b0;
      cycles = 1;
      n_checks++;
      if (busy !== 1'b1)
         $display("FAIL %s busy_after_load: got %b want 1", name, busy);
      if (busy !== 1'b1) n_fail++;
      exp_lat = 2; valid_cycles = 0; exp_valid = 0; in_coin = 0; got_done = 0;
      cnt = 0; d = 0; cur = 0;
      while (cycles < 2000) begin
         load = 1'b0; refill = 1'b0; eject_ack = 1'b0;
         if (done === 1'b1) begin
            got_done = 1'b1;
            break;
         end
         if (eject_valid === 1'b1) begin
            valid_cycles++;
            if (!in_coin) begin
               in_coin = 1'b1;
               cur = int'(eject_coin);
               obs_q.push_back(cur);
               d = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(max_delay, 0));
               cnt = 0;
               exp_lat += d + 2;
               exp_valid += d + 1;
            end else begin
               n_checks++;
               if (eject_coin !== 3'(cur)) begin
                  n_fail++;
                  $display("FAIL %s coin_stable: got %0d want %0d", name, eject_coin, cur);
               end
            end
            if (cnt == d) begin
               eject_ack = 1'b1;
               in_coin = 1'b0;
            end
            cnt++;
         end else begin
            n_checks++;
            if (eject_coin !== 3'd0) begin
               n_fail++;
               $display("FAIL %s coin_idle_zero: got %0d want 0", name, eject_coin);
            end
            eject_ack = noise ? 1'($urandom_range(1, 0)) : 1'b0;
         end
         if (noise) begin
            load = 1'($urandom_range(1, 0));
            change_in = 6'($urandom_range(63, 0));
            refill = 1'($urandom_range(1, 0));
         end
         @(negedge clk);
         cycles++;
      end
      n_checks++;
      if (!got_done) begin
         n_fail++;
         $display("FAIL %s done_timeout: got no done after %0d cycles want done", name, cycles);
      end
      seq_bad = (obs_q.size() != exp_q.size());
      if (!seq_bad)
         for (int i = 0; i < exp_q.size(); i++)
            if (obs_q[i] != exp_q[i]) seq_bad = 1'b1;
      n_checks++;
      if (seq_bad) begin
         n_fail++;
         $display("FAIL %s coin_seq: got %p want %p", name, obs_q, exp_q);
      end
      n_checks++;
      if (short !== exp_short) begin
         n_fail++;
         $display("FAIL %s short: got %b want %b", name, short, exp_short);
      end
      n_checks++;
      if (remaining !== 6'(exp_rem)) begin
         n_fail++;
         $display("FAIL %s remaining: got %0d want %0d", name, remaining, exp_rem);
      end
      n_checks++;
      if (cycles != exp_lat) begin
         n_fail++;
         $display("FAIL %s latency: got %0d want %0d", name, cycles, exp_lat);
      end
      n_checks++;
      if (valid_cycles != exp_valid) begin
         n_fail++;
         $display("FAIL %s valid_cycles: got %0d want %0d", name, valid_cycles, exp_valid);
      end
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL %s busy_in_done: got %b want 1", name, busy);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || eject_valid !== 1'b0 || short !== exp_short) begin
         n_fail++;
         $display("FAIL %s after_done: got done=%b busy=%b valid=%b short=%b want 0 0 0 %b",
                  name, done, busy, eject_valid, short, exp_short);
      end
      $display("txn %-12s amt=%0d coins=%p short=%0b rem=%0d cycles=%0d",
               name, amt, obs_q, short, remaining, cycles);
   endtask

   task automatic test_reset();
      reset = 1'b1; load = 1'b0; refill = 1'b0; eject_ack = 1'b0; change_in = 6'd0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({eject_valid, eject_coin, busy, done, short, remaining} !== 13'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%b coin=%0d busy=%b done=%b short=%b rem=%0d want all 0",
                  eject_valid, eject_coin, busy, done, short, remaining);
      end
      reset = 1'b0;
      model_refill();
      $display("txn reset        outputs checked");
   endtask

   task automatic test_basic();
      run_txn("basic", 40, 0, 0, 1'b0, 1'b0);
      run_txn("zero", 0, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_held_ack();
      run_txn("held_ack", 25, 3, 0, 1'b0, 1'b0);
   endtask

   task automatic test_fallback();
      do_refill();
      for (int i = 0; i < 4; i++) run_txn("drain_q", 50, 0, 0, 1'b0, 1'b0);
      run_txn("fallback", 30, 0, 0, 1'b0, 1'b0);
      run_txn("dimes_left", 60, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_short();
      do_refill();
      for (int i = 0; i < 4; i++) run_txn("drain_d", 20, 0, 0, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) run_txn("drain_n", 5, 0, 0, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) run_txn("drain_q", 25, 0, 0, 1'b0, 1'b0);
      run_txn("short", 40, 0, 0, 1'b0, 1'b0);
      do_refill();
      run_txn("after_refill", 10, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_penny();
      do_refill();
      run_txn("penny", 7, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_load_wins();
      do_refill();
      for (int i = 0; i < 4; i++) run_txn("drain_q", 50, 0, 0, 1'b0, 1'b0);
      run_txn("load_wins", 30, 0, 0, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid();
      int seen;
      bit coin_ok;
      do_refill();
      @(negedge clk);
      load = 1'b1; change_in = 6'd50; eject_ack = 1'b1;
      @(negedge clk);
      seen = 0;
      coin_ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         load = 1'b1;            // must be ignored while busy
         change_in = 6'd5;
         if (eject_valid === 1'b1) begin
            seen++;
            if (eject_coin !== 3'd3) coin_ok = 1'b0;
            if (seen == 2) break;
         end
         @(negedge clk);
      end
      load = 1'b0; eject_ack = 1'b0;
      n_checks++;
      if (seen != 2 || !coin_ok) begin
         n_fail++;
         $display("FAIL reset_mid_setup: got %0d quarter requests (ok=%b) want 2", seen, coin_ok);
      end
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({eject_valid, eject_coin, busy, done, short, remaining} !== 13'd0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: got valid=%b coin=%0d busy=%b done=%b short=%b rem=%0d want all 0",
                  eject_valid, eject_coin, busy, done, short, remaining);
      end
      reset = 1'b0;
      model_refill();
      $display("txn reset_mid    abandoned payout of 50 after %0d quarters", seen);
      for (int i = 0; i < 4; i++) run_txn("post_reset", 50, 0, 0, 1'b0, 1'b0);
      run_txn("post_reset", 63, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      do_refill();
      for (int t = 0; t < 30; t++) begin
         if ($urandom_range(3, 0) == 0) do_refill();
         run_txn("random", int'($urandom_range(63, 0)), -1, 2, 1'b1, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_held_ack();
      test_fallback();
      test_short();
      test_penny();
      test_load_wins();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
